aes256_key_expand: RTL and testbench
====================================

Name: aes256_key_expand

Overview:
- Iterative AES-256 key schedule (FIPS-197, Nk=8, Nr=14).
- Accepts a 256-bit cipher key and generates the 60 schedule words w[0..59] at one word per clock, using a single 4-byte S-box.
- Stores the result as 15 round keys in an internal register file.
- Sits directly upstream of the AES round controller, which reads round key r (encrypt: 0..14; decrypt: 14..0) through an indexed read port.

Parameters:
- REG_OUT, 1, 1 = rk_out registered (read latency 1 cycle); 0 = rk_out combinational from rk_idx.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- key_valid  in  1  key-load request.
- key  in  256  cipher key; key[255:224] = w[0], key[31:0] = w[7].
- key_ready  out  1  block can accept a new key this cycle.
- keys_valid  out  1  all 15 round keys for the last accepted key are stored.
- rk_idx  in  4  round-key index 0..14.
- rk_out  out  128  round key rk_idx = {w[4r], w[4r+1], w[4r+2], w[4r+3]}; w[4r] in bits 127:96.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, word counter i=0, rcon=8'h01.
  - key_ready=1, keys_valid=0, rk_out=0, word store cleared to 0.
- States: IDLE, EXPAND, READY.
  - IDLE: key_ready=1, keys_valid=0.
  - EXPAND: key_ready=0, keys_valid=0.
  - READY: key_ready=1, keys_valid=1.
- Accept:
  - key_valid & key_ready on a rising edge loads w[0..7] from key, sets i=8, rcon=01, state=EXPAND.
  - Accept from READY deasserts keys_valid on the next cycle; the old schedule is not preserved.
- EXPAND, one word per cycle, i=8..59:
  - temp = w[i-1].
  - If i%8==0: temp = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}, then rcon = xtime(rcon).
  - If i%8==4: temp = SubWord(w[i-1]).
  - w[i] = w[i-8] ^ temp.
  - rcon sequence: 01,02,04,08,10,20,40 (7 uses).
  - After writing w[59]: state=READY, keys_valid=1.
- Latency: accept at edge N; keys_valid=1 after edge N+52 (52 EXPAND cycles).
- key_valid while key_ready=0 is ignored; it is not queued.
- Read port:
  - REG_OUT=1: rk_out updates on the edge after rk_idx is presented.
  - REG_OUT=0: rk_out follows rk_idx combinationally.
  - rk_idx 15 returns 128'h0.
  - Reads are permitted in any state; contents are meaningful only while keys_valid=1.
- Reset mid-EXPAND: the schedule is aborted, all stored words are zeroed and state returns to IDLE. The next key starts a full 52-cycle expansion.
- S-box: one combinational 256-entry forward table, instantiated ×4 bytes. No inverse tables; the consumer applies the decryption key order itself.
- Width rules: all XORs are 32-bit; xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).

Test Plan:
- FIPS-197 A.3 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> keys_valid rises exactly 52 cycles after accept:
  - rk 0 = 603deb1015ca71be2b73aef0857d7781.
  - rk 1 = 1f352c073b6108d72d9810a30914dff4.
  - rk 2 = 9ba354118e6925afa51a8b5f2067fcde.
  - rk 14 = fe4890d1e6188d0b046df344706c631e.
- Sweep rk_idx 0..15 with REG_OUT=1 -> each value appears one cycle later; idx 15 -> 0.
- Hold key_valid=1 with a different key throughout EXPAND -> ignored, A.3 results unchanged. A second key accepted in READY -> keys_valid=0 next cycle, new schedule valid 52 cycles later.
- Assert rst=0 asynchronously at cycle 20 of EXPAND -> outputs immediately at reset values, rk_out=0. Reload the A.3 key -> identical results.
- All-zero key -> rk 1 = 0, rk 2 = 62636363626363636263636362636363.
- Back-to-back accept on the first cycle READY is entered -> key_ready=1 in that cycle and the accept takes effect.

Source files
------------

// File: rtl/aes256_key_expand.sv
// aes256_key_expand
//   Iterative AES-256 key schedule. A 256-bit cipher key is expanded into the
//   60 schedule words w[0..59] at one word per clock, using a single 4-byte
//   S-box. The words are held as 15 round keys behind an indexed read port.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   key_valid   key-load request
//   key         cipher key, key[255:224] = w[0] ... key[31:0] = w[7]
//   key_ready   a new key can be accepted this cycle
//   keys_valid  all 15 round keys of the last accepted key are stored
//   rk_idx      round-key index 0..14 (15 reads as zero)
//   rk_out      {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in bits 127:96
//
// Parameter
//   REG_OUT     1: rk_out registered (1-cycle read latency), 0: combinational
//
// state   | meaning
// S_IDLE  | no schedule held, waiting for a key
// S_EXPAND| generating w[8..59], one word per cycle
// S_READY | schedule complete, round keys valid

module aes256_key_expand #(
    parameter bit REG_OUT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [255:0] key,
    output logic         key_ready,
    output logic         keys_valid,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out
);

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [5:0] LAST_WORD = 6'd59;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_READY  = 2'd2
    } state_t;

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        logic [10:0] msb;
        msb = 11'd2047 - {b, 3'b000};
        return SBOX_TBL[msb -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sub_byte(x[31:24]), sub_byte(x[23:16]),
                sub_byte(x[15:8]),  sub_byte(x[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    state_t        state_q, state_d;
    logic [5:0]    i_q, i_d;
    logic [7:0]    rcon_q, rcon_d;
    logic [31:0]   w_q [60];
    logic [31:0]   w_d [60];
    logic          accept;
    logic [31:0]   prev_w;
    logic [31:0]   sub_in;
    logic [31:0]   sub_out;
    logic [31:0]   temp_w;
    logic [31:0]   new_w;
    logic [127:0]  rk_d;

    assign accept = key_valid & key_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_EXPAND;
            S_EXPAND: if (i_q == LAST_WORD) state_d = S_READY;
            S_READY:  if (accept) state_d = S_EXPAND;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        key_ready  = (state_q != S_EXPAND);
        keys_valid = (state_q == S_READY);
    end

    // ---------------- word generator ----------------
    // Only meaningful while expanding; the single S-box is shared between the
    // RotWord case (i%8==0) and the plain SubWord case (i%8==4).
    always_comb begin
        prev_w  = w_q[i_q - 6'd1];
        sub_in  = (i_q[2:0] == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
        sub_out = sub_word(sub_in);
        case (i_q[2:0])
            3'd0:    temp_w = sub_out ^ {rcon_q, 24'h0};
            3'd4:    temp_w = sub_out;
            default: temp_w = prev_w;
        endcase
        new_w = w_q[i_q - 6'd8] ^ temp_w;
    end

    always_comb begin
        w_d    = w_q;
        i_d    = i_q;
        rcon_d = rcon_q;
        if (accept) begin
            for (int k = 0; k < 8; k++) begin
                w_d[k] = key[255 - 32*k -: 32];
            end
            i_d    = 6'd8;
            rcon_d = 8'h01;
        end else if (state_q == S_EXPAND) begin
            w_d[i_q] = new_w;
            i_d      = i_q + 6'd1;
            if (i_q[2:0] == 3'd0) begin
                rcon_d = xtime(rcon_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_q    <= '0;
            rcon_q <= 8'h01;
            for (int k = 0; k < 60; k++) begin
                w_q[k] <= '0;
            end
        end else begin
            i_q    <= i_d;
            rcon_q <= rcon_d;
            w_q    <= w_d;
        end
    end

    // ---------------- read port ----------------
    always_comb begin
        rk_d = '0;
        if (rk_idx != 4'd15) begin
            rk_d = {w_q[{rk_idx, 2'b00}], w_q[{rk_idx, 2'b01}],
                    w_q[{rk_idx, 2'b10}], w_q[{rk_idx, 2'b11}]};
        end
    end

    generate
        if (REG_OUT) begin : g_reg_out
            logic [127:0] rk_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rk_q <= '0;
                end else begin
                    rk_q <= rk_d;
                end
            end
            assign rk_out = rk_q;
        end else begin : g_comb_out
            assign rk_out = rk_d;
        end
    endgenerate

endmodule

// File: tb/tb_aes256_key_expand.sv
// Testbench for aes256_key_expand (REG_OUT=1). Round-key reads are issued by
// the stimulus process, which pushes the expected value into a queue; a
// monitor pops and compares when the registered read data is presented.
module tb_aes256_key_expand;

    logic         clk;
    logic         rst;
    logic         key_valid;
    logic [255:0] key;
    logic         key_ready;
    logic         keys_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_m [256];
    logic [31:0]  mw [60];

    logic [127:0] exp_q [$];
    int           idx_q [$];
    logic         rd_issue;
    logic         rd_vld;

    aes256_key_expand #(.REG_OUT(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key        (key),
        .key_ready  (key_ready),
        .keys_valid (keys_valid),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = '0; x = a; y = b;
        for (int j = 0; j < 8; j++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword_m(input logic [31:0] v);
        return {sbox_m[v[31:24]], sbox_m[v[23:16]], sbox_m[v[15:8]], sbox_m[v[7:0]]};
    endfunction

    task automatic model_expand(input logic [255:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) mw[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = mw[i-1];
            if (i % 8 == 0) begin
                t  = subword_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (i % 8 == 4) begin
                t = subword_m(t);
            end
            mw[i] = mw[i-8] ^ t;
        end
    endtask

    function automatic logic [127:0] model_rk(input int r);
        if (r >= 15) return 128'h0;
        return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    always @(posedge clk) rd_vld <= rd_issue;

    always @(negedge clk) begin
        if (rd_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rk_read: got output with no expected entry, want none");
            end else begin
                logic [127:0] e;
                int           ix;
                e  = exp_q.pop_front();
                ix = idx_q.pop_front();
                checks++;
                if (rk_out !== e) begin
                    errors++;
                    $display("FAIL rk_read idx=%0d: got %h want %h", ix, rk_out, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue_read(input int idx, input logic [127:0] expv);
        rk_idx   = 4'(idx);
        exp_q.push_back(expv);
        idx_q.push_back(idx);
        rd_issue = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic end_reads();
        rd_issue = 1'b0;
        @(posedge clk); #1;
        chk("scoreboard_drain", exp_q.size(), 0);
    endtask

    task automatic sweep_all();
        for (int r = 0; r < 16; r++) issue_read(r, model_rk(r));
        end_reads();
    endtask

    task automatic random_reads(input int n);
        int r;
        for (int j = 0; j < n; j++) begin
            r = $urandom_range(0, 15);
            issue_read(r, model_rk(r));
        end
        end_reads();
    endtask

    task automatic kat_a3();
        logic [127:0] v;
        v = 128'h603deb1015ca71be2b73aef0857d7781; issue_read(0, v);
        v = 128'h1f352c073b6108d72d9810a30914dff4; issue_read(1, v);
        v = 128'h9ba354118e6925afa51a8b5f2067fcde; issue_read(2, v);
        v = 128'hfe4890d1e6188d0b046df344706c631e; issue_read(14, v);
        end_reads();
    endtask

    // Entered and left at #1 after a rising edge. Leaves the bench in the
    // first READY cycle so a following call exercises a back-to-back accept.
    task automatic load_key(input logic [255:0] k, input bit hold_junk, input string tag);
        int cnt;
        bit rdy_bad;
        chk({tag, "_ready_before"}, key_ready, 1);
        key       = k;
        key_valid = 1'b1;
        @(posedge clk); #1;
        model_expand(k);
        chk({tag, "_kv_low_after_accept"}, keys_valid, 0);
        key_valid = hold_junk;
        key       = hold_junk ? ~k : '0;
        cnt       = 0;
        rdy_bad   = 1'b0;
        while (keys_valid !== 1'b1 && cnt < 200) begin
            if (key_ready !== 1'b0) rdy_bad = 1'b1;
            @(posedge clk); #1;
            cnt++;
        end
        key_valid = 1'b0;
        key       = '0;
        chk({tag, "_latency"}, cnt, 52);
        chk({tag, "_ready_low_in_expand"}, rdy_bad, 0);
        chk({tag, "_ready_in_ready"}, key_ready, 1);
    endtask

    initial begin
        logic [255:0] a3;
        logic [255:0] rkey;
        logic [127:0] v;

        build_sbox();
        rst       = 1'b0;
        key_valid = 1'b0;
        key       = '0;
        rk_idx    = '0;
        rd_issue  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_key_ready", key_ready, 1);
        chk("reset_keys_valid", keys_valid, 0);
        chk("reset_rk_out", rk_out, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // A.3 key with a different key requested throughout the expansion
        a3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        load_key(a3, 1'b1, "a3_hold");
        kat_a3();
        sweep_all();

        // all-zero key, accepted from READY
        load_key(256'h0, 1'b0, "zero");
        v = 128'h0;                               issue_read(1, v);
        v = 128'h62636363626363636263636362636363; issue_read(2, v);
        end_reads();
        sweep_all();

        // random keys, with random read patterns
        for (int n = 0; n < 4; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
            load_key(rkey, 1'b0, "rand");
            random_reads(12);
        end

        // back-to-back: the A.3 load lands in the first READY cycle of a random key
        rkey = {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
        load_key(rkey, 1'b0, "rand_b2b");
        load_key(a3, 1'b0, "a3_b2b");
        kat_a3();
        sweep_all();

        // reset in the middle of an expansion
        key       = a3;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        key       = '0;
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_key_ready", key_ready, 1);
        chk("midrst_keys_valid", keys_valid, 0);
        chk("midrst_rk_out", rk_out, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("after_rst_keys_valid", keys_valid, 0);
        issue_read(0, 128'h0);
        issue_read(1, 128'h0);
        issue_read(14, 128'h0);
        end_reads();
        load_key(a3, 1'b0, "a3_after_rst");
        kat_a3();
        sweep_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
